spike_rate_decoder: RTL and testbench

//  Receive-side counterpart of the LIF neuron: turns a 1-bit spike train back into numbers.

---
 rtl/spike_pkg.sv | 20 ++
 rtl/sat_counter.sv | 22 ++
 rtl/spike_rate_decoder.sv | 134 +++++++++++++
 tb/tb_spike_rate_decoder.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/spike_pkg.sv
// Shared constants and types for the spike encode/decode blocks.
package spike_pkg;

  localparam int unsigned DEFAULT_WINDOW = 64;
  localparam int unsigned DEFAULT_CNT_W  = 8;
  localparam int unsigned DEFAULT_ISI_W  = 8;
  localparam int unsigned LIF_THRESHOLD  = 40;

  typedef struct packed {
    logic [DEFAULT_CNT_W-1:0] rate;
    logic [DEFAULT_ISI_W-1:0] isi;
    logic                     isi_ok;
  } rate_result_t;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } dec_state_t;

endpackage

// File: rtl/sat_counter.sv
// Unsigned up-counter that sticks at all-ones; synchronous clear has priority over increment.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/spike_rate_decoder.sv
// Decodes a spike train into per-window {rate, last ISI} results over a valid/ready port.
module spike_rate_decoder
  import spike_pkg::*;
#(
  parameter int unsigned WINDOW = DEFAULT_WINDOW,
  parameter int unsigned CNT_W  = DEFAULT_CNT_W,
  parameter int unsigned ISI_W  = DEFAULT_ISI_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             spike,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_rate,
  output logic [ISI_W-1:0] out_isi,
  output logic             out_isi_ok,
  output logic             overrun
);

  localparam int unsigned WIN_W = (WINDOW > 2) ? $clog2(WINDOW) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);

  dec_state_t state, state_next;
  logic       run;

  logic [WIN_W-1:0] win_cnt;
  logic [CNT_W-1:0] spk_cnt;
  logic [ISI_W-1:0] isi_cnt;
  logic [ISI_W-1:0] last_isi;
  logic             seen1;
  logic             isi_ok;

  logic             win_end;
  logic             isi_hit;
  logic [CNT_W:0]   rate_inc;
  logic [ISI_W:0]   isi_inc;
  logic [CNT_W-1:0] cand_rate;
  logic [ISI_W-1:0] cand_isi;
  logic             cand_isi_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    run        = 1'b0;
    case (state)
      IDLE: begin
        if (enable) begin
          run        = 1'b1;
          state_next = ACCUM;
        end
      end
      ACCUM: begin
        if (enable) run        = 1'b1;
        else        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        win_cnt <= '0;
    else if (!run || win_cnt == WIN_LAST) win_cnt <= '0;
    else                            win_cnt <= win_cnt + 1'b1;
  end

  assign win_end = run && (win_cnt == WIN_LAST);
  assign isi_hit = run && spike && seen1;

  sat_counter #(.W(CNT_W)) u_spk_cnt (
    .clk (clk),
    .rst (rst),
    .clr (!run || win_end),
    .inc (spike),
    .q   (spk_cnt)
  );

  sat_counter #(.W(ISI_W)) u_isi_cnt (
    .clk (clk),
    .rst (rst),
    .clr (!run || spike),
    .inc (1'b1),
    .q   (isi_cnt)
  );

  // Candidate values fold in the current cycle so a spike on the window-end cycle counts.
  assign rate_inc    = {1'b0, spk_cnt} + 1'b1;
  assign isi_inc     = {1'b0, isi_cnt} + 1'b1;
  assign cand_rate   = !spike ? spk_cnt : (rate_inc[CNT_W] ? '1 : rate_inc[CNT_W-1:0]);
  assign cand_isi    = !isi_hit ? last_isi : (isi_inc[ISI_W] ? '1 : isi_inc[ISI_W-1:0]);
  assign cand_isi_ok = isi_ok | isi_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seen1    <= 1'b0;
      isi_ok   <= 1'b0;
      last_isi <= '0;
    end else if (!run) begin
      seen1    <= 1'b0;
      isi_ok   <= 1'b0;
      last_isi <= '0;
    end else begin
      if (spike) seen1 <= 1'b1;
      last_isi <= cand_isi;
      isi_ok   <= cand_isi_ok;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_rate   <= '0;
      out_isi    <= '0;
      out_isi_ok <= 1'b0;
      overrun    <= 1'b0;
    end else if (win_end) begin
      if (out_valid && !out_ready) begin
        overrun <= 1'b1;
      end else begin
        out_valid  <= 1'b1;
        out_rate   <= cand_rate;
        out_isi    <= cand_isi;
        out_isi_ok <= cand_isi_ok;
      end
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Directed bench for spike_rate_decoder with WINDOW=16 (plus a CNT_W=3 instance for saturation).
module tb_spike_rate_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       spike;
  logic       out_ready;
  logic       out_valid;
  logic [7:0] out_rate;
  logic [7:0] out_isi;
  logic       out_isi_ok;
  logic       overrun;

  logic       v3;
  logic [2:0] rate3;
  logic [7:0] isi3;
  logic       ok3;
  logic       ovr3;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  spike_rate_decoder #(.WINDOW(16), .CNT_W(8), .ISI_W(8)) dut (
    .clk(clk), .rst(rst), .enable(enable), .spike(spike),
    .out_valid(out_valid), .out_ready(out_ready), .out_rate(out_rate),
    .out_isi(out_isi), .out_isi_ok(out_isi_ok), .overrun(overrun)
  );

  spike_rate_decoder #(.WINDOW(16), .CNT_W(3), .ISI_W(8)) dut3 (
    .clk(clk), .rst(rst), .enable(enable), .spike(spike),
    .out_valid(v3), .out_ready(out_ready), .out_rate(rate3),
    .out_isi(isi3), .out_isi_ok(ok3), .overrun(ovr3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic go_idle();
    enable = 1'b0;
    spike  = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b0; enable = 1'b0; spike = 1'b0; out_ready = 1'b1;
    #2;
    do_reset();
    check("rst_valid",   out_valid,  0);
    check("rst_rate",    out_rate,   0);
    check("rst_isi",     out_isi,    0);
    check("rst_isi_ok",  out_isi_ok, 0);
    check("rst_overrun", overrun,    0);

    // Every 4th cycle: rate 4, isi 4 in both windows
    enable = 1'b1;
    for (int c = 0; c < 32; c++) begin
      spike = (c % 4 == 0);
      tick();
      if (c == 14) check("t1_no_early_valid", out_valid, 0);
      if (c == 15 || c == 31) begin
        check("t1_valid",  out_valid,  1);
        check("t1_rate",   out_rate,   4);
        check("t1_isi",    out_isi,    4);
        check("t1_isi_ok", out_isi_ok, 1);
      end
      if (c == 16) check("t1_valid_drop", out_valid, 0);
    end
    go_idle();

    // Solid spikes: rate 16 (and 7 on the 3-bit instance), isi 1
    enable = 1'b1;
    for (int c = 0; c < 16; c++) begin
      spike = 1'b1;
      tick();
    end
    check("t2_rate",   out_rate, 16);
    check("t2_isi",    out_isi,  1);
    check("t2_valid3", v3,       1);
    check("t2_rate3",  rate3,    7);
    go_idle();

    // Silence after reset: three empty results
    do_reset();
    enable = 1'b1;
    for (int c = 0; c < 48; c++) begin
      spike = 1'b0;
      tick();
      if (c % 16 == 15) begin
        check("t3_valid",  out_valid,  1);
        check("t3_rate",   out_rate,   0);
        check("t3_isi",    out_isi,    0);
        check("t3_isi_ok", out_isi_ok, 0);
      end
    end
    go_idle();

    // Backpressure: window k carries k+1 leading spikes
    enable = 1'b1;
    for (int c = 0; c < 48; c++) begin
      out_ready = (c >= 40);
      spike     = ((c % 16) <= (c / 16));
      tick();
      if (c == 15) begin
        check("t4_first_rate",   out_rate,   1);
        check("t4_first_isi_ok", out_isi_ok, 0);
      end
      if (c == 30) check("t4_no_overrun_yet", overrun, 0);
      if (c == 31) check("t4_overrun", overrun, 1);
      if (c == 39) begin
        check("t4_hold_valid", out_valid, 1);
        check("t4_hold_rate",  out_rate,  1);
      end
      if (c == 40) check("t4_transfer", out_valid, 0);
      if (c == 47) begin
        check("t4_third_valid",  out_valid,  1);
        check("t4_third_rate",   out_rate,   3);
        check("t4_third_isi",    out_isi,    1);
        check("t4_third_isi_ok", out_isi_ok, 1);
        check("t4_overrun_sticky", overrun,  1);
      end
    end
    go_idle();

    // Enable dropped at window cycle 9: partial window never published
    out_ready = 1'b1;
    tick();
    enable = 1'b1;
    for (int c = 0; c < 9; c++) begin
      spike = 1'b1;
      tick();
    end
    for (int c = 0; c < 5; c++) begin
      enable = 1'b0;
      spike  = 1'b0;
      tick();
      check("t5_no_partial", out_valid, 0);
    end
    enable = 1'b1;
    for (int c = 0; c < 16; c++) begin
      spike = (c == 0 || c == 3);
      tick();
      if (c == 14) check("t5_not_yet", out_valid, 0);
    end
    check("t5_valid", out_valid, 1);
    check("t5_rate",  out_rate,  2);
    check("t5_isi",   out_isi,   3);
    go_idle();

    // Asynchronous reset mid-window with a held result
    out_ready = 1'b0;
    enable    = 1'b1;
    for (int c = 0; c < 23; c++) begin
      spike = (c % 5 == 0);
      tick();
    end
    check("t6_pre_valid", out_valid, 1);
    #2 rst = 1'b1;
    #1;
    check("t6_async_valid",   out_valid,  0);
    check("t6_async_rate",    out_rate,   0);
    check("t6_async_isi_ok",  out_isi_ok, 0);
    check("t6_async_overrun", overrun,    0);
    #2 rst = 1'b0;
    out_ready = 1'b1;
    enable    = 1'b1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      spike = (c == 2 || c == 8);
      @(posedge clk);
      #1;
    end
    check("t6_isi",    out_isi,    6);
    check("t6_isi_ok", out_isi_ok, 1);
    check("t6_rate",   out_rate,   2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
